// File: rtl/rca_seq_ctrl_pkg.sv
// rtl/rca_seq_ctrl_pkg.sv - shared constants and state encoding for the nibble-serial adder
package rca_seq_ctrl_pkg;

    localparam int NIB_W        = 4;
    localparam int NNIB_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - 4-bit ripple-carry adder
module rca
    import rca_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    // One full adder per bit, carry chained from bit 0 upward.
    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial adder: one 4-bit ripple-carry adder reused over NNIB cycles
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int NNIB = NNIB_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIB_W*NNIB-1:0] a,
    input  logic [NIB_W*NNIB-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NIB_W*NNIB-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W    = NIB_W * NNIB;
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NNIB - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] add_sum;
    logic             add_cout;
    int               nib_lsb;

    // Select the current nibble of each operand for the shared adder.
    always_comb begin
        nib_lsb = int'(idx_q) * NIB_W;
        nib_a   = a_q[nib_lsb +: NIB_W];
        nib_b   = b_q[nib_lsb +: NIB_W];
    end

    rca u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Control FSM: accept operands, ripple one nibble per cycle, hold result until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[nib_lsb +: NIB_W] = add_sum;
                carry_d                 = add_cout;
                if (idx_q == IDX_LAST) begin
                    // add_sum[3] is the final sum MSB being written this edge.
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[NIB_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - self-checking bench for rca_seq_ctrl
module tb_rca_seq_ctrl;

    localparam int NNIB = 4;
    localparam int W    = 4 * NNIB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[7];

    rca_seq_ctrl #(.NNIB(NNIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        logic [W:0] t;
        logic       v;
        t = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        v = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
        return {t, v};
    endfunction

    // Called #1 after a rising edge with the block idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input int stall, output logic [W-1:0] rs, output logic rc,
                          output logic ro, output int lat);
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tbv; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) check("out_valid_timeout", 0, 1);
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            check("stall_hold", {out_valid, in_ready, sum, cout, ovf}, {1'b1, 1'b0, rs, rc, ro});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_to_idle", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc, ro;
        int           lat;
        logic [W+1:0] m;

        vecs[0] = '{16'h0006, 16'h000C, 1'b0, 16'h0012, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        #12;
        check("reset_outputs", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("no_start_after_reset", {in_ready, out_valid}, 2'b10);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, rs, rc, ro, lat);
            check($sformatf("vec%0d_latency", i), lat, NNIB);
            check($sformatf("vec%0d_result", i), {rs, rc, ro},
                  {vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf});
        end

        // Partial sums: unwritten nibbles read 0, sum cleared on acceptance
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sum_cleared_on_accept", sum, 16'h0000);
        @(posedge clk); #1; check("partial_nib0", sum, 16'h0005);
        @(posedge clk); #1; check("partial_nib1", sum, 16'h0055);
        @(posedge clk); #1; check("partial_nib2", sum, 16'h0555);
        @(posedge clk); #1; check("partial_done", {out_valid, sum}, {1'b1, 16'h5555});

        // Long stall in DONE with new operands offered
        a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("done_stall", {out_valid, in_ready, sum}, {1'b1, 1'b0, 16'h5555});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("done_release", {out_valid, in_ready}, 2'b01);

        // Reset during the second ADD cycle
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_add_reset", {in_ready, out_valid, sum, cout, ovf}, {1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {in_ready, out_valid}, 2'b10);
        run_op(16'h1234, 16'h4321, 1'b0, 0, rs, rc, ro, lat);
        check("post_reset_result", {rs, rc}, {16'h5555, 1'b0});

        // Random transactions against the arithmetic model
        for (int t = 0; t < 1000; t++) begin
            logic [W-1:0] ra, rb;
            logic         rcin;
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
            if (t % 8 == 0) ra = 16'hFFFF - rb;
            run_op(ra, rb, rcin, $urandom_range(0, 3), rs, rc, ro, lat);
            m = model(ra, rb, rcin);
            check("rand_result", {lat[7:0], rc, rs, ro}, {8'(NNIB), m});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
